udp_header_gen: RTL and testbench
=================================

Name: udp_header_gen

Overview:
- Downstream consumer of the Ethernet configuration register block (MAC/IP/port settings).
- On a start request it snapshots the configuration and the payload length, then computes the IPv4 header checksum sequentially.
- It then streams the 42-byte Ethernet II + IPv4 + UDP header, one byte per accepted beat, over a valid/ready byte interface into the TX framer, which appends the payload.

Parameters:
TTL, 8'h40, IPv4 time-to-live byte.
DF_FLAG, 1, 1 sets IPv4 flags/fragment word to 16'h4000; 0 sets it to 16'h0000.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset_n  in  1  synchronous, active-low reset.
start  in  1  single-cycle header request; accepted only when busy=0.
payload_len  in  16  UDP payload bytes, sampled on accepted start.
local_port_i  in  16  UDP source port.
remote_port_i  in  16  UDP destination port.
local_IP_i  in  32  IPv4 source address.
remote_IP_i  in  32  IPv4 destination address.
local_MAC_LSB_i  in  32  source MAC bits [31:0].
local_MAC_MSB_i  in  32  source MAC bits [47:32] in [15:0]; [31:16] ignored.
remote_MAC_LSB_i  in  32  destination MAC bits [31:0].
remote_MAC_MSB_i  in  32  destination MAC bits [47:32] in [15:0]; [31:16] ignored.
busy  out  1  high from the cycle after an accepted start until the last byte is accepted.
tx_data  out  8  header byte.
tx_valid  out  1  tx_data valid.
tx_ready  in  1  downstream accepts the byte when tx_valid and tx_ready are both high.
tx_sop  out  1  high with byte 0.
tx_eop  out  1  high with byte 41.

Behaviour:
- Reset (reset_n=0 at a clock edge, any state): state IDLE; busy, tx_valid, tx_sop, tx_eop = 0; tx_data = 8'h00; IP identification counter = 16'h0000. A reset mid-header aborts the header with no further bytes.
- FSM IDLE -> CALC -> FOLD -> SEND -> IDLE.
- IDLE: start=1 snapshots all config inputs and payload_len into internal registers, then moves to CALC. In every other state start is ignored. Inputs changing after the snapshot have no effect on the current header.
- Arithmetic (16-bit, modulo 2^16, no range check):
  - ip_len = payload_len + 28
  - udp_len = payload_len + 8
- CALC: 10 cycles. Adds one IPv4 header word per cycle into a 20-bit accumulator cleared on entry. Word order:
  - 16'h4500
  - ip_len
  - ID
  - flags word
  - {TTL, 8'h11}
  - 16'h0000 (checksum field)
  - src IP high word, src IP low word
  - dst IP high word, dst IP low word
- FOLD: 1 cycle. s = acc[15:0] + acc[19:16]; s = s[15:0] + s[16]; csum = ~s[15:0].
- SEND: byte index 0..41. Layout, multi-byte fields MSB first:
  - 0-5: dst MAC
  - 6-11: src MAC
  - 12-13: 08 00
  - 14: 45; 15: 00
  - 16-17: ip_len
  - 18-19: ID
  - 20-21: flags word
  - 22: TTL; 23: 11
  - 24-25: csum
  - 26-29: src IP
  - 30-33: dst IP
  - 34-35: src port
  - 36-37: dst port
  - 38-39: udp_len
  - 40-41: 00 00 (UDP checksum disabled)
- Latency: start accepted at cycle N; busy=1 from N+1; first tx_valid at N+12.
- Handshake:
  - tx_valid stays high through the whole of SEND.
  - While tx_ready=0, tx_data, tx_sop and tx_eop hold their values.
  - The index advances only on an accepted beat.
  - tx_ready is allowed to be high before tx_valid, and to toggle every cycle.
- On acceptance of byte 41:
  - tx_valid, busy, tx_eop drop the next cycle.
  - ID increments by 1 (16'hFFFF wraps to 16'h0000).
  - Return to IDLE; a new start is accepted in that IDLE cycle (next header N+1 onward).
- start asserted in the same cycle byte 41 is accepted: ignored (busy still 1).

Test Plan:
- Defaults (local IP C0A80004, remote IP C0A80005, ports AAAA/FDE2, local MAC 74EA3A851BD7, remote MAC FFFFFFFFFFFF), payload_len=18, tx_ready=1 -> 42 bytes: FF×6, 74 EA 3A 85 1B D7, 08 00 45 00 00 2E 00 00 40 00 40 11 B9 65 C0 A8 00 04 C0 A8 00 05 AA AA FD E2 00 1A 00 00; sop on byte 0, eop on byte 41; first valid 12 cycles after start.
- Same config, second packet -> ID bytes 00 01, checksum B964.
- tx_ready random 50% duty -> identical byte sequence; data held stable on every stalled cycle.
- start pulsed during CALC and SEND, and config changed mid-SEND -> ignored; header unchanged.
- reset_n=0 at byte 20 -> next cycle tx_valid=0, busy=0; next start yields ID 00 00.
- payload_len=16'hFFF0 -> ip_len 000C, udp_len FFF8 (wrap); checksum consistent with wrapped ip_len.

Source files
------------

// File: rtl/udp_header_gen.sv
// UDP/IPv4/Ethernet II header generator: snapshots config on start, sums the IPv4
// header over 10 cycles, folds the checksum, then streams 42 header bytes over valid/ready.
//
// state | meaning
// IDLE  | waiting for start; config and payload_len snapshot taken on accepted start
// CALC  | adding one IPv4 header word per cycle into the 20-bit accumulator (10 cycles)
// FOLD  | end-around carry fold and one's complement into csum
// SEND  | presenting header byte byte_idx (0..41); advances on each accepted beat
module udp_header_gen #(
    parameter logic [7:0] TTL     = 8'h40,
    parameter bit         DF_FLAG = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] payload_len,
    input  logic [15:0] local_port_i,
    input  logic [15:0] remote_port_i,
    input  logic [31:0] local_IP_i,
    input  logic [31:0] remote_IP_i,
    input  logic [31:0] local_MAC_LSB_i,
    input  logic [31:0] local_MAC_MSB_i,
    input  logic [31:0] remote_MAC_LSB_i,
    input  logic [31:0] remote_MAC_MSB_i,
    output logic        busy,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_sop,
    output logic        tx_eop
);
    typedef enum logic [1:0] {IDLE, CALC, FOLD, SEND} state_t;

    localparam logic [15:0] FLAGS_WORD = DF_FLAG ? 16'h4000 : 16'h0000;
    localparam logic [5:0]  LAST_BYTE  = 6'd41;
    localparam logic [3:0]  CALC_LOAD  = 4'd9;

    state_t state, state_next;

    logic [47:0] dst_mac, src_mac;
    logic [31:0] src_ip, dst_ip;
    logic [15:0] src_port, dst_port, ip_len, udp_len;
    logic [15:0] ip_id, csum;
    logic [19:0] acc;
    logic [3:0]  calc_cnt;
    logic [5:0]  byte_idx;
    logic [15:0] calc_word;
    logic [16:0] fold1;
    logic [15:0] fold2;
    logic [0:41][7:0] hdr;
    logic        beat, last_beat;
    logic        unused_mac_hi;

    assign unused_mac_hi = ^{local_MAC_MSB_i[31:16], remote_MAC_MSB_i[31:16]};

    assign beat      = (state == SEND) && tx_ready;
    assign last_beat = beat && (byte_idx == LAST_BYTE);

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (calc_cnt == 4'd0) state_next = FOLD;
            FOLD:    state_next = SEND;
            SEND:    if (last_beat) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // calc_cnt counts down; word order is fixed by the header layout, first word at 9
    always_comb begin
        calc_word = 16'h0000;
        case (calc_cnt)
            4'd9:    calc_word = 16'h4500;
            4'd8:    calc_word = ip_len;
            4'd7:    calc_word = ip_id;
            4'd6:    calc_word = FLAGS_WORD;
            4'd5:    calc_word = {TTL, 8'h11};
            4'd4:    calc_word = 16'h0000;
            4'd3:    calc_word = src_ip[31:16];
            4'd2:    calc_word = src_ip[15:0];
            4'd1:    calc_word = dst_ip[31:16];
            4'd0:    calc_word = dst_ip[15:0];
            default: calc_word = 16'h0000;
        endcase
    end

    assign fold1 = {1'b0, acc[15:0]} + {13'd0, acc[19:16]};
    assign fold2 = fold1[15:0] + {15'd0, fold1[16]};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dst_mac  <= '0;
            src_mac  <= '0;
            src_ip   <= '0;
            dst_ip   <= '0;
            src_port <= '0;
            dst_port <= '0;
            ip_len   <= '0;
            udp_len  <= '0;
            ip_id    <= '0;
            csum     <= '0;
            acc      <= '0;
            calc_cnt <= '0;
            byte_idx <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    dst_mac  <= {remote_MAC_MSB_i[15:0], remote_MAC_LSB_i};
                    src_mac  <= {local_MAC_MSB_i[15:0], local_MAC_LSB_i};
                    src_ip   <= local_IP_i;
                    dst_ip   <= remote_IP_i;
                    src_port <= local_port_i;
                    dst_port <= remote_port_i;
                    ip_len   <= payload_len + 16'd28;
                    udp_len  <= payload_len + 16'd8;
                    acc      <= '0;
                    calc_cnt <= CALC_LOAD;
                end
                CALC: begin
                    acc      <= acc + {4'd0, calc_word};
                    calc_cnt <= calc_cnt - 4'd1;
                end
                FOLD: begin
                    csum     <= ~fold2;
                    byte_idx <= '0;
                end
                SEND: if (beat) begin
                    if (last_beat) ip_id <= ip_id + 16'd1;
                    else           byte_idx <= byte_idx + 6'd1;
                end
                default: ;
            endcase
        end
    end

    assign hdr = {dst_mac, src_mac, 16'h0800, 8'h45, 8'h00, ip_len, ip_id, FLAGS_WORD,
                  TTL, 8'h11, csum, src_ip, dst_ip, src_port, dst_port, udp_len, 16'h0000};

    // outputs decode from registered state so a stall holds them without extra flops
    assign busy     = (state != IDLE);
    assign tx_valid = (state == SEND);
    assign tx_data  = (state == SEND) ? hdr[byte_idx] : 8'h00;
    assign tx_sop   = (state == SEND) && (byte_idx == 6'd0);
    assign tx_eop   = (state == SEND) && (byte_idx == LAST_BYTE);

endmodule

// File: tb/tb_udp_header_gen.sv
// Self-checking bench for udp_header_gen: random configs and tx_ready patterns
// compared against a byte-list reference model of the 42-byte header.
module tb_udp_header_gen;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] payload_len;
    logic [15:0] local_port_i, remote_port_i;
    logic [31:0] local_IP_i, remote_IP_i;
    logic [31:0] local_MAC_LSB_i, local_MAC_MSB_i, remote_MAC_LSB_i, remote_MAC_MSB_i;
    logic        busy;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_sop;
    logic        tx_eop;

    int total = 0;
    int bad   = 0;
    logic [15:0] model_id;
    logic [7:0]  exp_hdr [42];
    logic [7:0]  got     [42];
    logic [7:0]  spec_vec [42] = '{
        8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h74, 8'hEA, 8'h3A, 8'h85, 8'h1B, 8'hD7,
        8'h08, 8'h00, 8'h45, 8'h00, 8'h00, 8'h2E, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
        8'hB9, 8'h65, 8'hC0, 8'hA8, 8'h00, 8'h04, 8'hC0, 8'hA8, 8'h00, 8'h05, 8'hAA, 8'hAA,
        8'hFD, 8'hE2, 8'h00, 8'h1A, 8'h00, 8'h00};

    udp_header_gen dut (
        .clk(clk), .reset_n(reset_n), .start(start), .payload_len(payload_len),
        .local_port_i(local_port_i), .remote_port_i(remote_port_i),
        .local_IP_i(local_IP_i), .remote_IP_i(remote_IP_i),
        .local_MAC_LSB_i(local_MAC_LSB_i), .local_MAC_MSB_i(local_MAC_MSB_i),
        .remote_MAC_LSB_i(remote_MAC_LSB_i), .remote_MAC_MSB_i(remote_MAC_MSB_i),
        .busy(busy), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_sop(tx_sop), .tx_eop(tx_eop));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_defaults();
        payload_len      = 16'd18;
        local_port_i     = 16'hAAAA;
        remote_port_i    = 16'hFDE2;
        local_IP_i       = 32'hC0A80004;
        remote_IP_i      = 32'hC0A80005;
        local_MAC_MSB_i  = 32'h000074EA;
        local_MAC_LSB_i  = 32'h3A851BD7;
        remote_MAC_MSB_i = 32'h0000FFFF;
        remote_MAC_LSB_i = 32'hFFFFFFFF;
    endtask

    task automatic randomize_cfg();
        payload_len      = 16'($urandom);
        local_port_i     = 16'($urandom);
        remote_port_i    = 16'($urandom);
        local_IP_i       = $urandom;
        remote_IP_i      = $urandom;
        local_MAC_MSB_i  = $urandom;
        local_MAC_LSB_i  = $urandom;
        remote_MAC_MSB_i = $urandom;
        remote_MAC_LSB_i = $urandom;
    endtask

    // Reference: header as a list of bytes; checksum by one's-complement sum of 10 words
    task automatic build_model();
        logic [15:0] ip_len, udp_len, csum;
        logic [47:0] dmac, smac;
        int unsigned sum;
        int unsigned words [10];
        logic [7:0] q [$];
        ip_len  = payload_len + 16'd28;
        udp_len = payload_len + 16'd8;
        dmac = {remote_MAC_MSB_i[15:0], remote_MAC_LSB_i};
        smac = {local_MAC_MSB_i[15:0], local_MAC_LSB_i};
        words = '{32'h4500, {16'h0, ip_len}, {16'h0, model_id}, 32'h4000, 32'h4011, 32'h0,
                  {16'h0, local_IP_i[31:16]}, {16'h0, local_IP_i[15:0]},
                  {16'h0, remote_IP_i[31:16]}, {16'h0, remote_IP_i[15:0]}};
        sum = 0;
        foreach (words[i]) sum += words[i];
        while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
        csum = ~sum[15:0];
        q = {};
        for (int i = 5; i >= 0; i--) q.push_back(dmac[8*i +: 8]);
        for (int i = 5; i >= 0; i--) q.push_back(smac[8*i +: 8]);
        q.push_back(8'h08); q.push_back(8'h00); q.push_back(8'h45); q.push_back(8'h00);
        q.push_back(ip_len[15:8]);   q.push_back(ip_len[7:0]);
        q.push_back(model_id[15:8]); q.push_back(model_id[7:0]);
        q.push_back(8'h40); q.push_back(8'h00); q.push_back(8'h40); q.push_back(8'h11);
        q.push_back(csum[15:8]);     q.push_back(csum[7:0]);
        for (int i = 3; i >= 0; i--) q.push_back(local_IP_i[8*i +: 8]);
        for (int i = 3; i >= 0; i--) q.push_back(remote_IP_i[8*i +: 8]);
        q.push_back(local_port_i[15:8]);  q.push_back(local_port_i[7:0]);
        q.push_back(remote_port_i[15:8]); q.push_back(remote_port_i[7:0]);
        q.push_back(udp_len[15:8]);  q.push_back(udp_len[7:0]);
        q.push_back(8'h00); q.push_back(8'h00);
        for (int i = 0; i < 42; i++) exp_hdr[i] = q[i];
    endtask

    // One header request; abort_at >= 0 pulses reset when that byte is on the bus
    task automatic run_pkt(input string tag, input bit rnd_ready, input bit disturb, input int abort_at);
        int lat, idx, cyc;
        bit rdy, prev_stall;
        logic [7:0] prev_data;
        logic [15:0] s_len, s_lp, s_rp;
        logic [31:0] s_lip, s_rip, s_lml, s_lmm, s_rml, s_rmm;
        s_len = payload_len; s_lp = local_port_i; s_rp = remote_port_i;
        s_lip = local_IP_i; s_rip = remote_IP_i;
        s_lml = local_MAC_LSB_i; s_lmm = local_MAC_MSB_i;
        s_rml = remote_MAC_LSB_i; s_rmm = remote_MAC_MSB_i;
        build_model();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_start"}, busy, 1);
        lat = 1;
        while (!tx_valid && lat < 40) begin
            tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            start = disturb && (lat == 5);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, lat, 12);
        idx = 0; cyc = 0; prev_stall = 1'b0; prev_data = 8'h00;
        while (idx < 42 && cyc < 500) begin
            if (idx == abort_at) begin
                reset_n = 1'b0;
                @(negedge clk);
                chk({tag, "_abort_valid"}, tx_valid, 0);
                chk({tag, "_abort_busy"}, busy, 0);
                chk({tag, "_abort_data"}, tx_data, 0);
                reset_n = 1'b1;
                model_id = 16'h0000;
                repeat (3) begin
                    @(negedge clk);
                    chk({tag, "_abort_quiet"}, tx_valid, 0);
                end
                return;
            end
            chk({tag, "_valid"}, tx_valid, 1);
            chk({tag, "_busy"}, busy, 1);
            chk($sformatf("%s_byte%0d", tag, idx), tx_data, exp_hdr[idx]);
            chk({tag, "_sop"}, tx_sop, (idx == 0));
            chk({tag, "_eop"}, tx_eop, (idx == 41));
            if (prev_stall) chk({tag, "_hold"}, tx_data, prev_data);
            got[idx] = tx_data;
            rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tx_ready = rdy;
            start = disturb && (idx == 20 || (idx == 41 && rdy));
            if (disturb && idx == 10) begin
                randomize_cfg();
            end
            prev_data = tx_data;
            prev_stall = !rdy;
            if (rdy) idx++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        tx_ready = 1'b0;
        chk({tag, "_done"}, idx, 42);
        chk({tag, "_end_valid"}, tx_valid, 0);
        chk({tag, "_end_busy"}, busy, 0);
        chk({tag, "_end_eop"}, tx_eop, 0);
        model_id = model_id + 16'd1;
        payload_len = s_len; local_port_i = s_lp; remote_port_i = s_rp;
        local_IP_i = s_lip; remote_IP_i = s_rip;
        local_MAC_LSB_i = s_lml; local_MAC_MSB_i = s_lmm;
        remote_MAC_LSB_i = s_rml; remote_MAC_MSB_i = s_rmm;
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        tx_ready = 1'b0;
        model_id = 16'h0000;
        set_defaults();
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", tx_valid, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_sop", tx_sop, 0);
        chk("rst_eop", tx_eop, 0);
        reset_n = 1'b1;
        @(negedge clk);

        run_pkt("p1", 1'b0, 1'b0, -1);
        for (int i = 0; i < 42; i++) chk($sformatf("p1_spec%0d", i), got[i], spec_vec[i]);

        run_pkt("p2", 1'b0, 1'b0, -1);
        chk("p2_id_hi", got[18], 8'h00);
        chk("p2_id_lo", got[19], 8'h01);
        chk("p2_cs_hi", got[24], 8'hB9);
        chk("p2_cs_lo", got[25], 8'h64);

        run_pkt("p3_stall", 1'b1, 1'b0, -1);
        run_pkt("p4_disturb", 1'b1, 1'b1, -1);

        run_pkt("p5_abort", 1'b0, 1'b0, 20);
        run_pkt("p6_after_rst", 1'b0, 1'b0, -1);
        chk("p6_id_hi", got[18], 8'h00);
        chk("p6_id_lo", got[19], 8'h00);

        payload_len = 16'hFFF0;
        run_pkt("p7_wrap", 1'b1, 1'b0, -1);
        chk("p7_iplen_hi", got[16], 8'h00);
        chk("p7_iplen_lo", got[17], 8'h0C);
        chk("p7_udplen_hi", got[38], 8'hFF);
        chk("p7_udplen_lo", got[39], 8'hF8);

        for (int k = 0; k < 5; k++) begin
            randomize_cfg();
            run_pkt($sformatf("rnd%0d", k), 1'b1, (k == 2), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
